// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the RV32I execute stage and a word-organised data
// memory. Each byte/halfword/word access, aligned or not, becomes one or two
// word-aligned memory transactions with byte enables; load data is shifted
// down to bit 0 and sign- or zero-extended. The core stalls on lsu_busy.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lsu_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       w_data,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic [31:0]       r_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        DONE
    } state_t;

    state_t state;

    // Request decode (only meaningful while IDLE)
    logic [3:0]        size_mask;
    logic [7:0]        lane_mask;
    logic [63:0]       wdata_sh;
    logic [ADDR_W-1:0] word0_addr;
    logic [ADDR_W-1:0] word1_addr;
    logic              request;
    logic              illegal;

    // Per-access context held for the second word and the load extension
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic              split_q;
    logic [3:0]        be1_q;
    logic [31:0]       wdata1_q;
    logic [ADDR_W-1:0] addr1_q;
    logic [31:0]       rbuf_lo;

    // Shift the two-word read buffer down by the byte offset, then extend
    // to 32 bits according to the load type.
    function automatic logic [31:0] load_extend(input logic [63:0] dword,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] lane;
        logic [31:0] res;
        lane = 32'(dword >> {off, 3'b000});
        case (f3)
            F3_B:    res = {{24{lane[7]}}, lane[7:0]};
            F3_H:    res = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   res = {24'h000000, lane[7:0]};
            F3_HU:   res = {16'h0000, lane[15:0]};
            F3_W:    res = lane;
            default: res = lane;
        endcase
        return res;
    endfunction

    // Byte-lane mask, lane-aligned store data and word addresses of the request
    always_comb begin
        case (func3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_mask  = {4'b0000, size_mask} << addr[1:0];
        wdata_sh   = {32'h0000_0000, w_data} << {addr[1:0], 3'b000};
        word0_addr = {addr[ADDR_W-1:2], 2'b00};
        // Natural wrap of the adder takes the last word back to address 0
        word1_addr = word0_addr + ADDR_W'(4);
        request    = lsu_valid && (MemRead || MemWrite);
        illegal    = (MemRead && MemWrite)
                  || (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7)
                  || (MemWrite && func3[2]);
    end

    // Capture access context on accept and the low read word after the first beat
    always_ff @(posedge clk) begin
        if (state == IDLE && request && !illegal) begin
            off_q    <= addr[1:0];
            f3_q     <= func3;
            split_q  <= |lane_mask[7:4];
            be1_q    <= lane_mask[7:4];
            wdata1_q <= wdata_sh[63:32];
            addr1_q  <= word1_addr;
        end
        if (state == WAIT0 && mem_rvalid) begin
            rbuf_lo <= mem_rdata;
        end
    end

    // Access sequencing FSM; every core- and memory-side output is registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lsu_busy  <= 1'b0;
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            r_data    <= 32'h0000_0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
        end else begin
            lsu_done <= 1'b0;
            lsu_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        if (illegal) begin
                            lsu_err <= 1'b1;
                        end else begin
                            state     <= REQ0;
                            lsu_busy  <= 1'b1;
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= word0_addr;
                            mem_be    <= MemWrite ? lane_mask[3:0] : 4'b1111;
                            mem_wdata <= wdata_sh[31:0];
                        end
                    end
                end
                REQ0: begin
                    if (mem_gnt) begin
                        if (mem_we) begin
                            if (split_q) begin
                                // Back-to-back second write; mem_req stays high
                                state     <= REQ1;
                                mem_addr  <= addr1_q;
                                mem_be    <= be1_q;
                                mem_wdata <= wdata1_q;
                            end else begin
                                state    <= DONE;
                                mem_req  <= 1'b0;
                                lsu_done <= 1'b1;
                            end
                        end else begin
                            state   <= WAIT0;
                            mem_req <= 1'b0;
                        end
                    end
                end
                WAIT0: begin
                    if (mem_rvalid) begin
                        if (split_q) begin
                            state    <= REQ1;
                            mem_req  <= 1'b1;
                            mem_addr <= addr1_q;
                            mem_be   <= 4'b1111;
                        end else begin
                            state    <= DONE;
                            lsu_done <= 1'b1;
                            r_data   <= load_extend({32'h0000_0000, mem_rdata}, off_q, f3_q);
                        end
                    end
                end
                REQ1: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state    <= DONE;
                            lsu_done <= 1'b1;
                        end else begin
                            state <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        state    <= DONE;
                        lsu_done <= 1'b1;
                        r_data   <= load_extend({mem_rdata, rbuf_lo}, off_q, f3_q);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    lsu_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    lsu_busy <= 1'b0;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule
